// File: rtl/csr_access_ctrl.sv
// Sequences one Zicsr instruction: reads the CSR, optionally writes the new value
// back in a single strobe cycle, then returns the old value over a valid/ready channel.
module csr_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [4:0]  req_rs1_idx,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rd_idx,
  output logic        csr_wr_en,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd_idx,
  output logic        resp_rd_we,
  output logic [31:0] resp_data,
  output logic        resp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [4:0]  rs1Idx_q;
  logic [31:0] rs1Data_q;
  logic [4:0]  rdIdx_q;
  logic [31:0] old_q;
  logic        illegal_q;

  logic        reqFire;
  logic [31:0] srcVal;
  logic [31:0] newVal;
  logic        writeNeeded;
  logic        illegalNow;

  assign reqFire = (state_q == IDLE) && req_valid && !flush && !rst;

  always_comb begin
    srcVal = funct3_q[2] ? {27'd0, rs1Idx_q} : rs1Data_q;
    newVal = 32'd0;
    case (funct3_q[1:0])
      2'b01:   newVal = srcVal;
      2'b10:   newVal = old_q | srcVal;
      2'b11:   newVal = old_q & ~srcVal;
      default: newVal = 32'd0;
    endcase
    // Set/clear with x0 (or uimm 0) is a pure read and must not touch the CSR
    writeNeeded = (funct3_q[1:0] == 2'b01) || (rs1Idx_q != 5'd0);
    illegalNow  = (funct3_q[1:0] == 2'b00) ||
                  (writeNeeded && (addr_q[11:10] == 2'b11));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q  <= 3'd0;
      addr_q    <= 12'd0;
      rs1Idx_q  <= 5'd0;
      rs1Data_q <= 32'd0;
      rdIdx_q   <= 5'd0;
      old_q     <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      if (reqFire) begin
        funct3_q  <= req_funct3;
        addr_q    <= req_addr;
        rs1Idx_q  <= req_rs1_idx;
        rs1Data_q <= req_rs1_data;
        rdIdx_q   <= req_rd_idx;
      end
      if (state_q == READ) begin
        old_q     <= csr_rdata;
        illegal_q <= illegalNow;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = READ;
      READ: begin
        if (illegalNow)       state_d = RESP;
        else if (writeNeeded) state_d = WRITE;
        else                  state_d = RESP;
      end
      WRITE: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Everything is forced to its idle value while reset is held
  always_comb begin
    req_ready    = 1'b0;
    csr_wr_en    = 1'b0;
    csr_op       = 3'd0;
    csr_addr     = 12'd0;
    csr_wdata    = 32'd0;
    resp_valid   = 1'b0;
    resp_rd_idx  = 5'd0;
    resp_rd_we   = 1'b0;
    resp_data    = 32'd0;
    resp_illegal = 1'b0;
    if (!rst) begin
      req_ready = (state_q == IDLE) && !flush;
      csr_op    = funct3_q;
      csr_addr  = addr_q;
      if (state_q == WRITE) begin
        csr_wr_en = !flush;
        csr_wdata = newVal;
      end
      if (state_q == RESP) begin
        resp_valid   = 1'b1;
        resp_rd_idx  = rdIdx_q;
        resp_data    = illegal_q ? 32'd0 : old_q;
        resp_rd_we   = !illegal_q && (rdIdx_q != 5'd0);
        resp_illegal = illegal_q;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a one-register CSR file model.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd_idx;
  logic        csr_wr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd_idx;
  logic        resp_rd_we;
  logic [31:0] resp_data;
  logic        resp_illegal;

  int vectorCount = 0;
  int miscompareCount = 0;

  logic [31:0] csrVal;
  logic [31:0] loadVal;
  logic        loadEn = 1'b0;
  int          wrPulses = 0;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_rd_idx(req_rd_idx),
    .csr_wr_en(csr_wr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_idx(resp_rd_idx), .resp_rd_we(resp_rd_we),
    .resp_data(resp_data), .resp_illegal(resp_illegal)
  );

  // Single-entry CSR file: reads are address-independent, writes land on the edge
  assign csr_rdata = csrVal;
  always @(posedge clk) begin
    if (loadEn) begin
      csrVal <= loadVal;
    end else if (csr_wr_en) begin
      csrVal   <= csr_wdata;
      wrPulses <= wrPulses + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic presetCsr(input logic [31:0] v);
    loadVal = v;
    loadEn  = 1'b1;
    nextCycle();
    loadEn  = 1'b0;
    #1;
  endtask

  task automatic driveReq(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] rs1i, input logic [31:0] rs1d,
                          input logic [4:0] rd);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = addr;
    req_rs1_idx  = rs1i;
    req_rs1_data = rs1d;
    req_rd_idx   = rd;
  endtask

  // Full request with resp_ready high; checks every cycle of the expected timeline
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                               input logic [4:0] rs1i, input logic [31:0] rs1d, input logic [4:0] rd,
                               input logic expWr, input logic [31:0] expWdata,
                               input logic [31:0] expData, input logic expWe, input logic expIll);
    int startPulses;
    startPulses = wrPulses;
    resp_ready  = 1'b1;
    driveReq(f3, addr, rs1i, rs1d, rd);
    #1;
    checkOutput({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    nextCycle();
    req_valid = 1'b0;
    #1;
    checkOutput({tag, ".c1_addr"}, {20'd0, csr_addr}, {20'd0, addr});
    checkOutput({tag, ".c1_ready"}, {31'd0, req_ready}, 32'd0);
    checkOutput({tag, ".c1_wr"}, {31'd0, csr_wr_en}, 32'd0);
    nextCycle();
    if (expWr) begin
      checkOutput({tag, ".c2_wr"}, {31'd0, csr_wr_en}, 32'd1);
      checkOutput({tag, ".c2_wdata"}, csr_wdata, expWdata);
      checkOutput({tag, ".c2_op"}, {29'd0, csr_op}, {29'd0, f3});
      checkOutput({tag, ".c2_rvalid"}, {31'd0, resp_valid}, 32'd0);
      nextCycle();
    end
    checkOutput({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({tag, ".resp_wr"}, {31'd0, csr_wr_en}, 32'd0);
    checkOutput({tag, ".resp_data"}, resp_data, expData);
    checkOutput({tag, ".resp_we"}, {31'd0, resp_rd_we}, {31'd0, expWe});
    checkOutput({tag, ".resp_ill"}, {31'd0, resp_illegal}, {31'd0, expIll});
    checkOutput({tag, ".resp_rd"}, {27'd0, resp_rd_idx}, {27'd0, rd});
    nextCycle();
    checkOutput({tag, ".idle_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, ".pulses"}, wrPulses - startPulses, {31'd0, expWr});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; resp_ready = 1'b1;
    driveReq(3'b001, 12'h340, 5'd1, 32'h1, 5'd1);
    #1;
    checkOutput("rst.req_ready_held", {31'd0, req_ready}, 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("rst.req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst.wr_en", {31'd0, csr_wr_en}, 32'd0);
    checkOutput("rst.addr", {20'd0, csr_addr}, 32'd0);
    checkOutput("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst.released_ready", {31'd0, req_ready}, 32'd1);

    presetCsr(32'h1234_5678);
    applyStimulus("csrrw", 3'b001, 12'h340, 5'd3, 32'hDEAD_BEEF, 5'd5,
                  1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    checkOutput("csrrw.csr_after", csrVal, 32'hDEAD_BEEF);

    presetCsr(32'h0000_00F0);
    applyStimulus("csrrs", 3'b010, 12'h340, 5'd6, 32'h0000_000F, 5'd2,
                  1'b1, 32'h0000_00FF, 32'h0000_00F0, 1'b1, 1'b0);
    presetCsr(32'h0000_00F0);
    applyStimulus("csrrci", 3'b111, 12'h340, 5'h10, 32'hFFFF_FFFF, 5'd2,
                  1'b1, 32'h0000_00E0, 32'h0000_00F0, 1'b1, 1'b0);
    presetCsr(32'h0000_00F0);
    applyStimulus("csrrs_x0", 3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd7,
                  1'b0, 32'd0, 32'h0000_00F0, 1'b1, 1'b0);
    applyStimulus("f3_100", 3'b100, 12'h340, 5'd1, 32'h1, 5'd4,
                  1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus("rw_ro", 3'b001, 12'hC00, 5'd1, 32'h1, 5'd4,
                  1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus("rs_x0_ro", 3'b010, 12'hC00, 5'd0, 32'h1, 5'd4,
                  1'b0, 32'd0, 32'h0000_00F0, 1'b1, 1'b0);
    applyStimulus("rwi_rd0", 3'b101, 12'h341, 5'h1F, 32'h0, 5'd0,
                  1'b1, 32'h0000_001F, 32'h0000_00F0, 1'b0, 1'b0);

    // Back-pressure: response must hold for five stalled cycles
    presetCsr(32'h0000_0ABC);
    resp_ready = 1'b0;
    driveReq(3'b010, 12'h300, 5'd0, 32'h0, 5'd9);
    nextCycle();
    req_valid = 1'b0;
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp.data", resp_data, 32'h0000_0ABC);
      checkOutput("bp.rd", {27'd0, resp_rd_idx}, 32'd9);
      checkOutput("bp.req_ready", {31'd0, req_ready}, 32'd0);
      nextCycle();
    end
    resp_ready = 1'b1;
    driveReq(3'b010, 12'h301, 5'd0, 32'h0, 5'd8);
    nextCycle();
    checkOutput("bp.idle_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("bp.idle_valid", {31'd0, resp_valid}, 32'd0);
    nextCycle();
    req_valid = 1'b0;
    #1;
    checkOutput("bp.next_addr", {20'd0, csr_addr}, 32'h301);
    checkOutput("bp.next_busy", {31'd0, req_ready}, 32'd0);
    nextCycle();
    checkOutput("bp.next_valid", {31'd0, resp_valid}, 32'd1);
    nextCycle();

    // Flush in WRITE: strobe suppressed, CSR untouched
    presetCsr(32'h0000_0011);
    driveReq(3'b001, 12'h340, 5'd2, 32'h0000_0022, 5'd3);
    nextCycle();
    req_valid = 1'b0;
    nextCycle();
    flush = 1'b1;
    #1;
    checkOutput("fl_wr.wr_en", {31'd0, csr_wr_en}, 32'd0);
    nextCycle();
    flush = 1'b0;
    #1;
    checkOutput("fl_wr.valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("fl_wr.idle", {31'd0, req_ready}, 32'd1);
    checkOutput("fl_wr.csr", csrVal, 32'h0000_0011);

    // Flush in RESP: response dropped
    resp_ready = 1'b0;
    driveReq(3'b010, 12'h340, 5'd0, 32'h0, 5'd3);
    nextCycle();
    req_valid = 1'b0;
    nextCycle();
    checkOutput("fl_resp.pre", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    #1;
    checkOutput("fl_resp.valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("fl_resp.idle", {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b1;

    // Flush in IDLE with a request present: not accepted
    driveReq(3'b001, 12'h7AA, 5'd1, 32'h5, 5'd1);
    flush = 1'b1;
    #1;
    checkOutput("fl_idle.ready", {31'd0, req_ready}, 32'd0);
    nextCycle();
    req_valid = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("fl_idle.still_idle", {31'd0, req_ready}, 32'd1);
    checkOutput("fl_idle.addr", {20'd0, csr_addr}, 32'h340);

    // Reset while in READ
    driveReq(3'b001, 12'h305, 5'd1, 32'h55, 5'd1);
    nextCycle();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid.ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_mid.wr_en", {31'd0, csr_wr_en}, 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rst_mid.addr", {20'd0, csr_addr}, 32'd0);
    checkOutput("rst_mid.op", {29'd0, csr_op}, 32'd0);
    checkOutput("rst_mid.wdata", csr_wdata, 32'd0);
    checkOutput("rst_mid.valid", {31'd0, resp_valid}, 32'd0);
    presetCsr(32'h0000_0100);
    applyStimulus("after_rst", 3'b010, 12'h305, 5'd4, 32'h0000_0003, 5'd6,
                  1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
